// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier datapath: counter sizing,
// control-strobe bit positions and a width-generic sign-extension helper.
package booth_pkg;

   localparam int SEXT_MAX = 64;

   // Shift-counter width for an accumulator of w bits (holds 0..w inclusive).
   function automatic int calc_cw(input int w);
      return $clog2(w) + 1;
   endfunction

   // Bit positions of the control unit's one-hot strobe vector.
   typedef enum int unsigned {
      CTL_CLR  = 0,
      CTL_ADD  = 1,
      CTL_SUB  = 2,
      CTL_SHR  = 3,
      CTL_SHR2 = 4,
      CTL_OE   = 5,
      CTL_NUM  = 6
   } ctl_bit_e;

   // Sign-extend the low w bits of v to SEXT_MAX bits; callers slice the result.
   function automatic logic [SEXT_MAX-1:0] sext(input logic [SEXT_MAX-1:0] v,
                                                input int unsigned w);
      logic [SEXT_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < SEXT_MAX; i++) begin
         r[i] = (i < int'(w)) ? v[i] : v[w-1];
      end
      return r;
   endfunction

endpackage

// File: rtl/booth_addsub.sv
// Combinational (WIDTH+1)-bit adder/subtractor for the accumulator datapath.
module booth_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           sub,
   output logic [WIDTH:0] y
);

   always_comb begin
      y = sub ? (a - b) : (a + b);
   end

endmodule

// File: rtl/booth_acc_reg.sv
// Booth accumulator (A) register: guarded add/sub, radix-2/4 arithmetic shift,
// saturating shift-position counter, done and sticky error flags.
module booth_acc_reg
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_b,
   input  logic                          clr,
   input  logic                          add,
   input  logic                          sub,
   input  logic                          shr,
   input  logic                          shr2,
   input  logic                          oe,
   input  logic [WIDTH-1:0]              operand,
   output logic [WIDTH-1:0]              acc_q,
   output logic [WIDTH-1:0]              obus,
   output logic [1:0]                    lsb_out,
   output logic [calc_cw(WIDTH)-1:0]     shift_cnt,
   output logic                          done,
   output logic                          err
);

   localparam int CW = calc_cw(WIDTH);

   logic [WIDTH:0]          acc;
   logic [WIDTH:0]          acc_nxt;
   logic [WIDTH:0]          op_ext;
   logic [WIDTH:0]          addend;
   logic [WIDTH:0]          t;
   logic [SEXT_MAX-1:0]     op_ext_full;
   logic [1:0]              lsb_nxt;
   logic [CW:0]             cnt_sum;
   logic [CW-1:0]           cnt_nxt;
   logic [CW-1:0]           cnt_inc;
   logic                    illegal;

   assign op_ext_full = sext(SEXT_MAX'(operand), WIDTH);
   assign op_ext      = op_ext_full[WIDTH:0];
   assign illegal     = (add & sub) | (shr & shr2);

   // With neither add nor sub the adder passes acc through unchanged.
   assign addend = (add | sub) ? op_ext : '0;

   booth_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (acc),
      .b   (addend),
      .sub (sub),
      .y   (t)
   );

   // Shift phase operates on the post-add value so a Booth step fits in one cycle.
   always_comb begin
      acc_nxt = t;
      lsb_nxt = lsb_out;
      if (shr) begin
         acc_nxt = {t[WIDTH], t[WIDTH:1]};
         lsb_nxt = {1'b0, t[0]};
      end else if (shr2) begin
         acc_nxt = {t[WIDTH], t[WIDTH], t[WIDTH:2]};
         lsb_nxt = {t[1], t[0]};
      end
   end

   always_comb begin
      cnt_inc = '0;
      if (shr) begin
         cnt_inc = CW'(1);
      end else if (shr2) begin
         cnt_inc = CW'(2);
      end
      cnt_sum = {1'b0, shift_cnt} + {1'b0, cnt_inc};
      cnt_nxt = (cnt_sum > (CW+1)'(WIDTH)) ? CW'(WIDTH) : cnt_sum[CW-1:0];
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         acc       <= '0;
         lsb_out   <= '0;
         shift_cnt <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else if (clr) begin
         acc       <= '0;
         lsb_out   <= '0;
         shift_cnt <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else if (illegal) begin
         err       <= 1'b1;
      end else begin
         acc       <= acc_nxt;
         lsb_out   <= lsb_nxt;
         shift_cnt <= cnt_nxt;
         done      <= (cnt_nxt == CW'(WIDTH));
      end
   end

   assign acc_q = acc[WIDTH-1:0];
   assign obus  = oe ? acc_q : 'z;

endmodule

// File: tb/tb_booth_acc_reg.sv
// Directed, table-driven bench for booth_acc_reg at WIDTH=8.
module tb_booth_acc_reg;

   logic       clk;
   logic       rst_b;
   logic       clr, add, sub, shr, shr2, oe;
   logic [7:0] operand;
   logic [7:0] acc_q;
   logic [7:0] obus;
   logic [1:0] lsb_out;
   logic [3:0] shift_cnt;
   logic       done;
   logic       err;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic       clr, add, sub, shr, shr2;
      logic [7:0] op;
      logic [7:0] e_acc;
      logic [1:0] e_lsb;
      logic [3:0] e_cnt;
      logic       e_done;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   booth_acc_reg #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .clr       (clr),
      .add       (add),
      .sub       (sub),
      .shr       (shr),
      .shr2      (shr2),
      .oe        (oe),
      .operand   (operand),
      .acc_q     (acc_q),
      .obus      (obus),
      .lsb_out   (lsb_out),
      .shift_cnt (shift_cnt),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Strobe encoding: c=clr a=add s=sub r=shr q=shr2
   task automatic push(input logic c, input logic a, input logic s, input logic r,
                       input logic q, input logic [7:0] op, input logic [7:0] ea,
                       input logic [1:0] el, input logic [3:0] ec, input logic ed,
                       input logic ee);
      vec_t v;
      v.clr = c; v.add = a; v.sub = s; v.shr = r; v.shr2 = q; v.op = op;
      v.e_acc = ea; v.e_lsb = el; v.e_cnt = ec; v.e_done = ed; v.e_err = ee;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic c, input logic a, input logic s, input logic r,
                        input logic q, input logic [7:0] op);
      clr = c; add = a; sub = s; shr = r; shr2 = q; operand = op;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_b = 1'b0;
      oe    = 1'b1;
      drive(0, 0, 0, 0, 0, 8'h00);

      //          c a s r q  op     acc    lsb    cnt done err
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'h05, 8'h05, 2'b00, 4'd0, 0, 0);
      push(0,0,1,0,0, 8'h07, 8'hFE, 2'b00, 4'd0, 0, 0);
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'h7F, 8'h7F, 2'b00, 4'd0, 0, 0);
      push(0,1,0,1,0, 8'h7F, 8'h7F, 2'b00, 4'd1, 0, 0);
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'h7E, 8'h7E, 2'b00, 4'd0, 0, 0);
      push(0,1,0,1,0, 8'h01, 8'h3F, 2'b01, 4'd1, 0, 0);
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'h80, 8'h80, 2'b00, 4'd0, 0, 0);
      push(0,0,0,0,1, 8'h00, 8'hE0, 2'b00, 4'd2, 0, 0);
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'hE3, 8'hE3, 2'b00, 4'd0, 0, 0);
      push(0,0,0,0,1, 8'h00, 8'hF8, 2'b11, 4'd2, 0, 0);
      // eight single shifts, then saturation
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'h7F, 8'h7F, 2'b00, 4'd0, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h3F, 2'b01, 4'd1, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h1F, 2'b01, 4'd2, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h0F, 2'b01, 4'd3, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h07, 2'b01, 4'd4, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h03, 2'b01, 4'd5, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h01, 2'b01, 4'd6, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h00, 2'b01, 4'd7, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h00, 2'b00, 4'd8, 1, 0);
      push(0,1,0,0,0, 8'h40, 8'h40, 2'b00, 4'd8, 1, 0);
      push(0,0,0,1,0, 8'h00, 8'h20, 2'b00, 4'd8, 1, 0);
      // mixed 3x shr2 + 2x shr
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'h6C, 8'h6C, 2'b00, 4'd0, 0, 0);
      push(0,0,0,0,1, 8'h00, 8'h1B, 2'b00, 4'd2, 0, 0);
      push(0,0,0,0,1, 8'h00, 8'h06, 2'b11, 4'd4, 0, 0);
      push(0,0,0,0,1, 8'h00, 8'h01, 2'b10, 4'd6, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h00, 2'b01, 4'd7, 0, 0);
      push(0,0,0,1,0, 8'h00, 8'h00, 2'b00, 4'd8, 1, 0);
      // illegal combinations and sticky err
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);
      push(0,1,0,0,0, 8'h10, 8'h10, 2'b00, 4'd0, 0, 0);
      push(0,1,1,0,0, 8'h05, 8'h10, 2'b00, 4'd0, 0, 1);
      push(0,1,0,0,0, 8'h01, 8'h11, 2'b00, 4'd0, 0, 1);
      push(0,0,0,1,0, 8'h00, 8'h08, 2'b01, 4'd1, 0, 1);
      push(0,0,0,1,1, 8'h00, 8'h08, 2'b01, 4'd1, 0, 1);
      push(0,0,0,0,0, 8'h00, 8'h08, 2'b01, 4'd1, 0, 1);
      push(1,0,0,0,0, 8'h00, 8'h00, 2'b00, 4'd0, 0, 0);

      // reset state
      step();
      step();
      check("rst_acc",  16'(acc_q),     16'h00);
      check("rst_lsb",  16'(lsb_out),   16'h0);
      check("rst_cnt",  16'(shift_cnt), 16'h0);
      check("rst_done", 16'(done),      16'h0);
      check("rst_err",  16'(err),       16'h0);
      check("rst_obus", 16'(obus),      16'h00);
      rst_b = 1'b1;
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].add, vecs[i].sub, vecs[i].shr, vecs[i].shr2, vecs[i].op);
         step();
         check($sformatf("v%0d_acc", i),  16'(acc_q),     16'(vecs[i].e_acc));
         check($sformatf("v%0d_lsb", i),  16'(lsb_out),   16'(vecs[i].e_lsb));
         check($sformatf("v%0d_cnt", i),  16'(shift_cnt), 16'(vecs[i].e_cnt));
         check($sformatf("v%0d_done", i), 16'(done),      16'(vecs[i].e_done));
         check($sformatf("v%0d_err", i),  16'(err),       16'(vecs[i].e_err));
      end

      // bus readback, then async reset mid-sequence (acc=0x5A, shift_cnt=4)
      drive(1, 0, 0, 0, 0, 8'h00); step();
      drive(0, 0, 0, 0, 1, 8'h00); step();
      drive(0, 0, 0, 0, 1, 8'h00); step();
      drive(0, 1, 0, 0, 0, 8'h5A); step();
      drive(0, 0, 0, 0, 0, 8'h00);
      check("seq_acc", 16'(acc_q),     16'h5A);
      check("seq_cnt", 16'(shift_cnt), 16'h4);
      oe = 1'b1;
      #1;
      check("obus_on", 16'(obus), 16'h5A);
      oe = 1'b0;
      #1;
      n_cmp++;
      if (obus !== 8'hzz) begin
         n_bad++;
         $display("FAIL obus_off: got %h expected zz", obus);
      end
      check("oe_no_effect", 16'(acc_q), 16'h5A);
      rst_b = 1'b0;
      #1;
      check("arst_acc",  16'(acc_q),     16'h00);
      check("arst_cnt",  16'(shift_cnt), 16'h0);
      check("arst_done", 16'(done),      16'h0);
      check("arst_lsb",  16'(lsb_out),   16'h0);
      step();
      rst_b = 1'b1;
      drive(0, 1, 0, 0, 0, 8'h03); step();
      check("post_rst_acc", 16'(acc_q), 16'h03);
      drive(0, 0, 0, 0, 0, 8'h00); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/booth_acc_reg.md
Name: booth_acc_reg

Overview:
- Parametrised accumulator (A) register for the Booth multiplier datapath. Supersedes the fixed 8-bit A register.
- Adds the following:
  - a WIDTH parameter;
  - subtract as well as add;
  - a radix-4 double shift;
  - a fused add-then-shift cycle;
  - a guard bit so that 2M operands cannot overflow;
  - a shift-position counter with a done flag;
  - a sticky error flag for illegal control combinations.
- Driven by the control unit's one-hot strobes. Reads back onto the shared tri-state output bus.

Parameters:
- WIDTH, 8, accumulator width in bits (>= 4).
- CW, $clog2(WIDTH)+1, shift-counter width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- clr  in  1  clear accumulator, counter and flags.
- add  in  1  acc <= acc + sext(operand).
- sub  in  1  acc <= acc - sext(operand).
- shr  in  1  arithmetic shift right by 1.
- shr2  in  1  arithmetic shift right by 2 (radix-4).
- oe  in  1  drive obus.
- operand  in  WIDTH  two's-complement addend (M, 2M or 0 from the multiplicand path).
- acc_q  out  WIDTH  accumulator value, acc[WIDTH-1:0].
- obus  out  WIDTH  acc_q when oe=1, else high-Z (combinational).
- lsb_out  out  2  bits shifted out on the last shift: [0] first-out, [1] second-out (radix-4 only).
- shift_cnt  out  CW  shift positions accumulated since the last clr, saturating at WIDTH.
- done  out  1  shift_cnt == WIDTH (registered).
- err  out  1  sticky illegal-control flag.

Behaviour:
- Storage:
  - Internal acc is WIDTH+1 bits; bit WIDTH is the guard/sign bit.
  - operand is sign-extended to WIDTH+1.
  - All arithmetic is modulo 2^(WIDTH+1).
- Reset (rst_b=0, async):
  - acc=0, lsb_out=0, shift_cnt=0, done=0, err=0.
  - obus follows oe (0 when oe=1).
  - Reset mid-operation discards all state immediately.
- Priority each cycle:
  1. clr wins over everything. acc, lsb_out, shift_cnt, done and err all go to 0.
  2. Illegal combination: add&sub, or shr&shr2. acc, lsb_out and shift_cnt hold; err <= 1.
  3. Otherwise the arithmetic and shift phases below apply.
- Arithmetic phase (combinational):
  - t = acc + sext(operand) if add.
  - t = acc - sext(operand) if sub.
  - Otherwise t = acc.
- Shift phase, applied to t in the same cycle:
  - shr: acc <= {t[W], t[W:1]}; lsb_out <= {1'b0, t[0]}.
  - shr2: acc <= {t[W], t[W], t[W:2]}; lsb_out <= {t[1], t[0]}.
  - No shift: acc <= t; lsb_out holds.
  - Fused add/sub+shift therefore completes one Booth step in one cycle. Shifted-out bits are taken from the post-add value.
- Counter:
  - shift_cnt += 1 on shr, += 2 on shr2.
  - Saturates at WIDTH; an odd WIDTH with shr2 clamps to WIDTH.
  - Shifts after done still modify acc; the counter stays at WIDTH.
  - done is registered, asserting in the cycle after the counter reaches WIDTH.
- err clears only on clr or reset.
- No operation (all strobes 0): everything holds.
- obus: purely combinational tri-state. oe has no effect on register state.
- Latency: one clock from strobe to updated acc_q, lsb_out, shift_cnt and done.

Decomposition:
- Shared package booth_pkg:
  - localparam function for CW;
  - enum of control-strobe bit positions, for use by the control unit's one-hot vector;
  - a W-generic sext helper function.
- One natural sub-module: booth_addsub (WIDTH+1-bit add/subtract, combinational). The register, counter and flags stay in booth_acc_reg.

Test Plan (WIDTH=8):
- Reset then clr, add operand=0x05 -> acc_q=0x05; then sub operand=0x07 -> acc_q=0xFE, err=0.
- acc=0x7F, add+shr with operand=0x7F -> guard prevents overflow, acc_q=0x7F, lsb_out=2'b00. Repeat from acc=0x7E, operand=0x01, add+shr -> acc_q=0x3F, lsb_out=2'b01.
- acc=0x80, shr2 -> acc_q=0xE0, lsb_out=2'b00. Then acc=0xE3, shr2 -> acc_q=0xF8, lsb_out=2'b11.
- Eight single shr cycles after clr -> shift_cnt 1..8, done=1 after the 8th. A 9th shr -> shift_cnt stays 8, acc keeps shifting. Mixed: 3x shr2 + 2x shr -> shift_cnt=8, done=1.
- add&sub together with acc=0x10 -> acc_q stays 0x10, err=1; err persists through later legal ops; clr -> err=0.
- oe=1 -> obus==acc_q; oe=0 -> obus all Z. Assert rst_b=0 mid-sequence (acc=0x5A, shift_cnt=4) -> acc_q=0, shift_cnt=0, done=0 immediately, without waiting for a clock edge.
